// File: rtl/lsu_bus.sv
// lsu_bus: single-outstanding load/store unit bridging core requests onto a word-wide memory bus.
module lsu_bus #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64,
    parameter int TIMEOUT    = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_wen,
    input  logic [2:0]              req_func3,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    resp_valid,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_err,
    output logic                    mem_valid,
    input  logic                    mem_ready,
    output logic                    mem_wen,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);
    localparam int BW = DATA_WIDTH / 8;
    localparam int OW = $clog2(BW);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t                state, state_n;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
    logic [2:0]            func3_q;
    logic                  wen_q, err_q;
    logic [31:0]           cnt_q;

    logic [3:0]            req_size;
    logic [2:0]            amask;
    logic                  illegal, expire;
    logic [OW-1:0]         off;
    logic [BW-1:0]         strb;
    logic [DATA_WIDTH-1:0] bmask, topbit, shifted, ext;

    assign req_size = 4'd1 << req_func3[1:0];
    assign amask    = 3'(req_size - 4'd1);
    assign illegal  = (|(req_addr[2:0] & amask)) | (req_size > 4'(BW)) | (req_wen & req_func3[2]);

    assign off       = addr_q[OW-1:0];
    assign strb      = (func3_q[1:0] == 2'd0 ? BW'(1) :
                        func3_q[1:0] == 2'd1 ? BW'(3) :
                        func3_q[1:0] == 2'd2 ? BW'(4'hF) : '1) << off;
    assign mem_addr  = addr_q & ~ADDR_WIDTH'(BW - 1);
    assign mem_wdata = wdata_q << {off, 3'b000};

    // Loaded value is truncated with a byte mask; its top bit drives sign fill.
    assign bmask   = func3_q[1:0] == 2'd0 ? DATA_WIDTH'(8'hFF) :
                     func3_q[1:0] == 2'd1 ? DATA_WIDTH'(16'hFFFF) :
                     func3_q[1:0] == 2'd2 ? DATA_WIDTH'(32'hFFFF_FFFF) : '1;
    assign topbit  = bmask ^ (bmask >> 1);
    assign shifted = mem_rdata >> {off, 3'b000};
    assign ext     = (shifted & bmask) | ((!func3_q[2] && |(shifted & topbit)) ? ~bmask : '0);

    assign expire  = (TIMEOUT > 0) && (cnt_q == 32'(TIMEOUT - 1));

    always_comb begin
        state_n    = state;
        req_ready  = 1'b0;
        mem_valid  = 1'b0;
        mem_wen    = 1'b0;
        mem_wstrb  = '0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                state_n   = req_valid ? (illegal ? RESP : BUS) : IDLE;
            end
            BUS: begin
                mem_valid = 1'b1;
                mem_wen   = wen_q;
                mem_wstrb = strb;
                state_n   = (mem_ready || expire) ? RESP : BUS;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                resp_rdata = rdata_q;
                state_n    = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            func3_q <= '0;
            wen_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && req_valid) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                func3_q <= req_func3;
                wen_q   <= req_wen;
                err_q   <= illegal;
                rdata_q <= '0;
                cnt_q   <= '0;
            end
            if (state == BUS) begin
                cnt_q <= cnt_q + 32'd1;
                if (mem_ready) begin
                    err_q   <= 1'b0;
                    rdata_q <= wen_q ? '0 : ext;
                end else if (expire) begin
                    err_q <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_lsu_bus.sv
// tb_lsu_bus: randomized scoreboard bench for lsu_bus with a byte-level reference model.
module tb_lsu_bus;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_wen;
    logic [2:0]  req_func3;
    logic [63:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [63:0] resp_rdata;
    logic        mem_valid, mem_ready, mem_wen;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wstrb;

    logic        b_req_valid, b_req_ready, b_req_wen;
    logic [2:0]  b_req_func3;
    logic [31:0] b_req_addr, b_req_wdata;
    logic        b_resp_valid, b_resp_err;
    logic [31:0] b_resp_rdata;
    logic        b_mem_valid, b_mem_wen;
    logic        b_mem_ready = 1'b1;
    logic [31:0] b_mem_addr, b_mem_wdata;
    logic [31:0] b_mem_rdata = 32'h8000_0001;
    logic [3:0]  b_mem_wstrb;

    lsu_bus #(.DATA_WIDTH(64), .ADDR_WIDTH(64), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    lsu_bus #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(0)) dut32 (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_wen(b_req_wen),
        .req_func3(b_req_func3), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata), .resp_err(b_resp_err),
        .mem_valid(b_mem_valid), .mem_ready(b_mem_ready), .mem_wen(b_mem_wen),
        .mem_addr(b_mem_addr), .mem_wstrb(b_mem_wstrb), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic [63:0] rdata;
        int          cyc;
    } resp_t;

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  strb;
        logic [63:0] wdata;
        logic        wen;
        int          lat;
        logic [63:0] rword;
    } bus_t;

    resp_t exp_q[$];
    bus_t  bus_q[$];
    int    n_chk = 0;
    int    n_pass = 0;
    int    cyc = 0;
    bit    quiet = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Response monitor
    resp_t e;
    initial forever begin
        @(negedge clk);
        if (resp_valid) begin
            chk("resp_expected", 64'(quiet || exp_q.size() == 0), 64'd0);
            if (!quiet && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("resp_err", 64'(resp_err), 64'(e.err));
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Memory responder: checks bus fields every BUS cycle and answers after the scheduled latency
    bus_t cur;
    bit   active = 1'b0;
    int   bcnt = 0;
    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            mem_rdata = {$urandom, $urandom};
            if (quiet) active = 1'b0;
            else if (mem_valid) begin
                if (!active) begin
                    chk("bus_expected", 64'(bus_q.size() == 0), 64'd0);
                    if (bus_q.size() > 0) begin
                        cur = bus_q.pop_front();
                        active = 1'b1;
                        bcnt = 0;
                    end
                end
                if (active) begin
                    bcnt++;
                    chk("mem_addr", mem_addr, cur.addr);
                    chk("mem_wstrb", 64'(mem_wstrb), 64'(cur.strb));
                    chk("mem_wdata", mem_wdata, cur.wdata);
                    chk("mem_wen", 64'(mem_wen), 64'(cur.wen));
                    if (bcnt == cur.lat) begin
                        mem_ready = 1'b1;
                        mem_rdata = cur.rword;
                        active = 1'b0;
                    end else if (bcnt == 4) active = 1'b0;
                end
            end else if (active) begin
                chk("mem_valid_held", 64'(mem_valid), 64'd1);
                active = 1'b0;
            end
        end
    end

    // Reference model: byte-level view of size, lanes and extension; lat=0 means never ready
    task automatic issue(input logic wen, input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [63:0] rword, input int lat);
        int          k = 0;
        int          size = 1 << f3[1:0];
        int          off = int'(addr % 8);
        bit          legal, tmo;
        logic [63:0] val = '0;
        resp_t       r;
        bus_t        b;
        while (!req_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("req_ready_idle", 64'(req_ready), 64'd1);
        legal = (addr % 64'(size) == 0) && size <= 8 && !(wen && f3[2]);
        tmo   = lat == 0 || lat > 4;
        if (legal) begin
            for (int i = 0; i < size; i++) val[8*i +: 8] = rword[8*(off+i) +: 8];
            if (!f3[2] && val[8*size-1])
                for (int i = size; i < 8; i++) val[8*i +: 8] = 8'hFF;
        end
        r.err   = !legal || tmo;
        r.rdata = (r.err || wen) ? 64'd0 : val;
        r.cyc   = cyc + 1 + (legal ? (tmo ? 4 : lat) : 0);
        exp_q.push_back(r);
        if (legal) begin
            b.addr  = addr & ~64'h7;
            b.strb  = '0;
            for (int i = 0; i < size; i++) b.strb[off+i] = 1'b1;
            b.wdata = wdata << (8 * off);
            b.wen   = wen;
            b.lat   = lat;
            b.rword = rword;
            bus_q.push_back(b);
        end
        req_valid = 1'b1;
        req_wen   = wen;
        req_func3 = f3;
        req_addr  = addr;
        req_wdata = wdata;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = {$urandom, $urandom};
        req_wdata = {$urandom, $urandom};
        chk("req_ready_busy", 64'(req_ready), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  f3;
        logic [63:0] addr;
        int          sz;
        rst = 1'b1;
        req_valid = 1'b0; req_wen = 1'b0; req_func3 = '0; req_addr = '0; req_wdata = '0;
        b_req_valid = 1'b0; b_req_wen = 1'b0; b_req_func3 = '0; b_req_addr = '0; b_req_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_mem_valid", 64'(mem_valid), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_err", 64'(resp_err), 64'd0);
        chk("rst_resp_rdata", resp_rdata, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        issue(1'b0, 3'b000, 64'h8000_0003, 64'h0, 64'h0000_0000_8000_0000, 1);
        issue(1'b1, 3'b010, 64'h8000_0004, 64'h1122_3344_AABB_CCDD, 64'h0, 1);
        issue(1'b0, 3'b001, 64'h8000_0001, 64'h0, 64'h0, 1);
        issue(1'b0, 3'b011, 64'h8000_0008, 64'h0, 64'h1234_5678_9ABC_DEF0, 0);
        issue(1'b0, 3'b011, 64'h8000_0008, 64'h0, 64'h1234_5678_9ABC_DEF0, 4);
        issue(1'b1, 3'b110, 64'h8000_0000, 64'h55, 64'h0, 1);
        issue(1'b0, 3'b100, 64'h8000_0007, 64'h0, 64'hFF00_0000_0000_0000, 2);

        for (int n = 0; n < 200; n++) begin
            f3   = 3'($urandom_range(0, 7));
            sz   = 1 << f3[1:0];
            addr = 64'h8000_0000 + 64'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) addr = addr & ~64'(sz - 1);
            issue(1'($urandom), f3, addr, {$urandom, $urandom}, {$urandom, $urandom},
                  int'($urandom_range(1, 6)));
        end

        // Reset in the middle of a bus transaction
        repeat (6) @(negedge clk);
        quiet = 1'b1;
        req_valid = 1'b1; req_wen = 1'b0; req_func3 = 3'b011; req_addr = 64'h8000_0010;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rstbus_mem_valid_before", 64'(mem_valid), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstbus_mem_valid", 64'(mem_valid), 64'd0);
        chk("rstbus_req_ready", 64'(req_ready), 64'd1);
        chk("rstbus_resp_valid", 64'(resp_valid), 64'd0);
        repeat (4) begin
            @(negedge clk);
            chk("rstbus_no_resp", 64'(resp_valid), 64'd0);
        end
        quiet = 1'b0;
        issue(1'b0, 3'b010, 64'h8000_0004, 64'h0, 64'h8765_4321_0000_0000, 1);

        repeat (10) @(negedge clk);
        chk("resp_queue_drained", 64'(exp_q.size()), 64'd0);
        chk("bus_queue_drained", 64'(bus_q.size()), 64'd0);

        // 32-bit instance: doubleword is oversize; lwu is zero-extended
        b_req_valid = 1'b1; b_req_wen = 1'b0; b_req_func3 = 3'b011; b_req_addr = 32'h0;
        @(negedge clk);
        b_req_valid = 1'b0;
        chk("w32_ld_resp_valid", 64'(b_resp_valid), 64'd1);
        chk("w32_ld_resp_err", 64'(b_resp_err), 64'd1);
        chk("w32_ld_mem_valid", 64'(b_mem_valid), 64'd0);
        @(negedge clk);
        b_req_valid = 1'b1; b_req_func3 = 3'b110; b_req_addr = 32'h4;
        @(negedge clk);
        b_req_valid = 1'b0;
        chk("w32_lwu_mem_valid", 64'(b_mem_valid), 64'd1);
        chk("w32_lwu_mem_addr", 64'(b_mem_addr), 64'h4);
        chk("w32_lwu_mem_wstrb", 64'(b_mem_wstrb), 64'hF);
        @(negedge clk);
        chk("w32_lwu_resp_valid", 64'(b_resp_valid), 64'd1);
        chk("w32_lwu_resp_err", 64'(b_resp_err), 64'd0);
        chk("w32_lwu_resp_rdata", 64'(b_resp_rdata), 64'h8000_0001);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/lsu_bus.md
LSU_BUS -- requirements
Module: ysyx_22040729_LSU

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64: bus and register data width; legal values 32 and 64.
REQ-002 SHALL have parameter ADDR_WIDTH, default 64: address width.
REQ-003 SHALL have parameter TIMEOUT, default 0: maximum bus wait cycles; 0 disables the timeout.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port req_valid, input, 1: core presents an access.
REQ-007 SHALL have port req_ready, output, 1: LSU can accept an access.
REQ-008 SHALL have port req_wen, input, 1: 1 = store, 0 = load.
REQ-009 SHALL have port req_func3, input, 3: RISC-V funct3; bits [1:0] give size (1/2/4/8 bytes); bit [2] = zero-extend on load.
REQ-010 SHALL have port req_addr, input, ADDR_WIDTH: byte address.
REQ-011 SHALL have port req_wdata, input, DATA_WIDTH: store data, right-aligned.
REQ-012 SHALL have port resp_valid, output, 1: one-cycle completion pulse.
REQ-013 SHALL have port resp_rdata, output, DATA_WIDTH: extended load data; 0 for stores and errors.
REQ-014 SHALL have port resp_err, output, 1: access fault or misalignment, qualified by resp_valid.
REQ-015 SHALL have port mem_valid, output, 1: bus request.
REQ-016 SHALL have port mem_ready, input, 1: bus completion.
REQ-017 SHALL have port mem_wen, output, 1: bus write.
REQ-018 SHALL have port mem_addr, output, ADDR_WIDTH: request address aligned to DATA_WIDTH/8.
REQ-019 SHALL have port mem_wstrb, output, DATA_WIDTH/8: byte enables.
REQ-020 SHALL have port mem_wdata, output, DATA_WIDTH: lane-shifted write data.
REQ-021 SHALL have port mem_rdata, input, DATA_WIDTH: full bus word, sampled when mem_valid & mem_ready.

Function
REQ-022 SHALL implement states IDLE, BUS, RESP; req_ready = 1 only in IDLE.
REQ-023 SHALL, in IDLE when req_valid = 1, register addr/wdata/func3/wen and check legality in the same cycle (accept cycle N).
REQ-024 SHALL treat as illegal: addr not a multiple of size; size > DATA_WIDTH/8; store with func3[2] = 1. Illegal access -> RESP at N+1 with resp_err = 1 and no mem_valid.
REQ-025 SHALL, for legal access, enter BUS at N+1: mem_valid = 1; mem_addr, mem_wen, mem_wstrb and mem_wdata held stable until mem_ready.
REQ-026 SHALL set offset = addr mod (DATA_WIDTH/8); mem_wstrb = ((1<<size)-1) << offset for both loads and stores; mem_wdata = req_wdata << 8*offset.
REQ-027 SHALL, when mem_ready = 1 in BUS, capture mem_rdata >> 8*offset, truncate to size, then sign-extend (func3[2] = 0) or zero-extend; next state RESP.
REQ-028 SHALL, in RESP, assert resp_valid for exactly one cycle, then return to IDLE; minimum latency for a legal access is resp_valid at N+2.
REQ-029 SHALL, when TIMEOUT > 0, count BUS cycles from 1; if the count reaches TIMEOUT with mem_ready = 0, drop mem_valid and go to RESP with resp_err = 1. mem_ready in the same cycle as the expiry wins (normal completion).
REQ-030 SHALL ignore mem_ready outside BUS; SHALL drive mem_valid, mem_wen and mem_wstrb to 0 outside BUS.
REQ-031 SHALL accept no new request in BUS or RESP; back-to-back accesses therefore take at least 3 cycles each.

Reset
REQ-032 SHALL, on rst = 1 at a clock edge in any state (including mid-BUS), go to IDLE; mem_valid = 0, resp_valid = 0, resp_err = 0, resp_rdata = 0, timeout counter = 0. Outstanding bus transactions are abandoned.

Verification
REQ-033 SHALL be verified with: DATA_WIDTH = 64, lb addr 0x80000003, mem_rdata = 0x0000_0000_8000_0000, mem_ready at N+1 -> mem_addr 0x80000000, mem_wstrb 0x08, resp_rdata 0xFFFF_FFFF_FFFF_FF80 at N+2.
REQ-034 SHALL be verified with: sw addr 0x80000004, wdata 0x1122_3344_AABB_CCDD -> mem_wstrb 0xF0, mem_wdata[63:32] = 0xAABBCCDD, resp_rdata 0.
REQ-035 SHALL be verified with: lh addr 0x80000001 -> resp_err = 1 at N+1; mem_valid never asserted.
REQ-036 SHALL be verified with: TIMEOUT = 4 and mem_ready held 0 -> mem_valid high for 4 cycles, then resp_err = 1; repeat with mem_ready in cycle 4 -> resp_err = 0.
REQ-037 SHALL be verified with: DATA_WIDTH = 32, ld -> resp_err = 1; lwu addr 0x4, rdata 0x8000_0001 -> resp_rdata 0x8000_0001.
REQ-038 SHALL be verified with: rst asserted during BUS -> mem_valid = 0 next cycle, req_ready = 1, no resp_valid.
